// File: rtl/note_sequence_player.sv
// Note-pattern store and playback sequencer feeding the piezo tone generator.
// Idle: previews the note at cur_index. Play: steps notes 0..end_idx, each held TICK_CYCLES clocks.
module note_sequence_player #(
    parameter int NOTE_W      = 4,
    parameter int NUM_NOTES   = 8,
    parameter int IDX_W       = 3,
    parameter int TICK_CYCLES = 5000000,
    parameter logic [NOTE_W-1:0] REST_NOTE = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_enable,
    input  logic [NUM_NOTES*NOTE_W-1:0]   data_in,
    input  logic                          play_music,
    input  logic                          stop,
    input  logic [IDX_W-1:0]              max_index,
    input  logic [IDX_W-1:0]              cur_index,
    output logic [NOTE_W-1:0]             piezo_out,
    output logic [NOTE_W-1:0]             data_out,
    output logic [IDX_W-1:0]              play_index,
    output logic                          busy,
    output logic                          done
);

    localparam int TCW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TCW-1:0]   TICK_LAST = TCW'(TICK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NOTES - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t                        r_state, w_next_state;
    logic [NUM_NOTES*NOTE_W-1:0]   r_pattern, w_nxt_pattern;
    logic                          r_pm_q;
    logic [TCW-1:0]                r_tick, w_nxt_tick;
    logic [IDX_W-1:0]              r_end, w_nxt_end;
    logic [NOTE_W-1:0]             r_piezo, w_nxt_piezo;
    logic [NOTE_W-1:0]             r_dout;
    logic [IDX_W-1:0]              r_pidx, w_nxt_pidx;
    logic                          r_busy, w_nxt_busy;
    logic                          r_done, w_nxt_done;
    logic                          w_start;
    logic [IDX_W-1:0]              w_end_clamp;
    logic [IDX_W-1:0]              w_pidx_inc;

    function automatic logic [NOTE_W-1:0] slice(input logic [NUM_NOTES*NOTE_W-1:0] pat,
                                                input logic [IDX_W-1:0] idx);
        if (int'(idx) < NUM_NOTES)
            return pat[int'(idx)*NOTE_W +: NOTE_W];
        return REST_NOTE;
    endfunction

    assign w_start     = play_music & ~r_pm_q;
    assign w_end_clamp = (int'(max_index) > NUM_NOTES - 1) ? LAST_IDX : max_index;
    assign w_pidx_inc  = r_pidx + IDX_W'(1);

    always_comb begin
        w_next_state  = r_state;
        w_nxt_pattern = r_pattern;
        w_nxt_tick    = r_tick;
        w_nxt_end     = r_end;
        w_nxt_piezo   = r_piezo;
        w_nxt_pidx    = r_pidx;
        w_nxt_busy    = r_busy;
        w_nxt_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A write wins over start; piezo_out holds its value during the write cycle.
                if (write_enable) begin
                    w_nxt_pattern = data_in;
                end else if (w_start) begin
                    w_next_state = S_PLAY;
                    w_nxt_busy   = 1'b1;
                    w_nxt_pidx   = '0;
                    w_nxt_tick   = '0;
                    w_nxt_piezo  = slice(r_pattern, '0);
                    w_nxt_end    = w_end_clamp;
                end else begin
                    w_nxt_piezo = slice(r_pattern, cur_index);
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_next_state = S_IDLE;
                    w_nxt_busy   = 1'b0;
                    w_nxt_pidx   = '0;
                    w_nxt_tick   = '0;
                    w_nxt_piezo  = REST_NOTE;
                end else if (r_tick == TICK_LAST) begin
                    w_nxt_tick = '0;
                    if (r_pidx == r_end) begin
                        w_next_state = S_IDLE;
                        w_nxt_busy   = 1'b0;
                        w_nxt_pidx   = '0;
                        w_nxt_piezo  = REST_NOTE;
                        w_nxt_done   = 1'b1;
                    end else begin
                        w_nxt_pidx  = w_pidx_inc;
                        w_nxt_piezo = slice(r_pattern, w_pidx_inc);
                    end
                end else begin
                    w_nxt_tick = r_tick + TCW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_pm_q    <= 1'b0;
            r_tick    <= '0;
            r_end     <= '0;
            r_piezo   <= REST_NOTE;
            r_dout    <= '0;
            r_pidx    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pattern <= w_nxt_pattern;
            r_pm_q    <= play_music;
            r_tick    <= w_nxt_tick;
            r_end     <= w_nxt_end;
            r_piezo   <= w_nxt_piezo;
            r_dout    <= slice(r_pattern, cur_index);
            r_pidx    <= w_nxt_pidx;
            r_busy    <= w_nxt_busy;
            r_done    <= w_nxt_done;
        end
    end

    assign piezo_out  = r_piezo;
    assign data_out   = r_dout;
    assign play_index = r_pidx;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
